// File: rtl/subtractor_pkg.sv
// Shared constants and a behavioural reference for the ripple-borrow subtractor.
// ref_sub returns {bout, diff} packed with bout at bit position 'width'.
package subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned MAX_WIDTH     = 32;

    function automatic logic [MAX_WIDTH:0] ref_sub(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 bin,
        input int unsigned          width = DEFAULT_WIDTH
    );
        logic [MAX_WIDTH:0] one;
        logic [MAX_WIDTH:0] dmask;
        logic [MAX_WIDTH:0] full;
        one   = {{MAX_WIDTH{1'b0}}, 1'b1};
        dmask = (one << width) - one;
        full  = ({1'b0, a} & dmask) - ({1'b0, b} & dmask) - {{MAX_WIDTH{1'b0}}, bin};
        // Keep diff bits plus the borrow bit just above them.
        return full & (dmask | (dmask + one));
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit combinational full subtractor: d = a - b - bin, bo is the borrow out.
module full_subtractor_cell
    import subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: a chain of bit cells feeding one output
// register stage qualified by out_valid.
module full_subtractor
    import subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             out_valid_q;

    assign br[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .bin (br[i]),
            .d   (d[i]),
            .bo  (br[i+1])
        );
    end

    // Result registers only load on valid so idle inputs never reach the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q      <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                diff_q <= d;
                bout_q <= br[WIDTH];
            end
        end
    end

    assign diff      = diff_q;
    assign bout      = bout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench: four subtractor instances (WIDTH 1/4/8/16) share stimulus;
// a scoreboard queue holds expected results until the registered outputs appear.
module tb_full_subtractor;
    import subtractor_pkg::*;

    localparam int NDUT = 4;
    localparam int unsigned WIDTHS [NDUT] = '{1, 4, 8, 16};

    typedef struct packed {
        logic                  vld;
        logic [NDUT-1:0][15:0] diff;
        logic [NDUT-1:0]       bout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;

    logic [15:0] diff_v [NDUT];
    logic        bout_v [NDUT];
    logic        ov_v   [NDUT];

    logic [15:0] last_diff [NDUT];
    logic        last_bout [NDUT];
    exp_t        sb [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned W = WIDTHS[g];
        logic [W-1:0] d;
        full_subtractor #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .a         (a[W-1:0]),
            .b         (b[W-1:0]),
            .bin       (bin),
            .out_valid (ov_v[g]),
            .diff      (d),
            .bout      (bout_v[g])
        );
        assign diff_v[g] = 16'(d);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int g = 0; g < NDUT; g++) begin
            last_diff[g] = '0;
            last_bout[g] = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_w%0d_valid", tag, WIDTHS[g]), 32'(ov_v[g]), 32'd0);
            check($sformatf("%s_w%0d_diff", tag, WIDTHS[g]), 32'(diff_v[g]), 32'd0);
            check($sformatf("%s_w%0d_bout", tag, WIDTHS[g]), 32'(bout_v[g]), 32'd0);
        end
    endtask

    // Drive one vector at the falling edge, predict, then compare just after the rising edge.
    task automatic step(input logic [15:0] av, input logic [15:0] bv, input logic binv,
                        input logic vldv);
        exp_t        e;
        logic [32:0] r;
        logic [32:0] dmask;
        @(negedge clk);
        a        = av;
        b        = bv;
        bin      = binv;
        in_valid = vldv;
        e.vld    = vldv;
        for (int g = 0; g < NDUT; g++) begin
            if (vldv) begin
                r            = ref_sub(32'(av), 32'(bv), binv, WIDTHS[g]);
                dmask        = (33'd1 << WIDTHS[g]) - 33'd1;
                last_diff[g] = r[15:0] & dmask[15:0];
                last_bout[g] = r[WIDTHS[g]];
            end
            e.diff[g] = last_diff[g];
            e.bout[g] = last_bout[g];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("w%0d_valid", WIDTHS[g]), 32'(ov_v[g]), 32'(e.vld));
            check($sformatf("w%0d_diff", WIDTHS[g]), 32'(diff_v[g]), 32'(e.diff[g]));
            check($sformatf("w%0d_bout", WIDTHS[g]), 32'(bout_v[g]), 32'(e.bout[g]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] tt [8];
        logic [2:0] abc;
        tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

        rst      = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        clear_model();
        #1 rst = 1'b1;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset with a result sitting in the output register.
        step(16'h0005, 16'h0003, 1'b1, 1'b1);
        check("pending_w8_valid", 32'(ov_v[2]), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h00ff;
        b        = 16'h0001;
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        clear_model();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            step(16'(abc[2]), 16'(abc[1]), abc[0], 1'b1);
            check($sformatf("tt%0d_diff", i), 32'(diff_v[0]), 32'(tt[i][1]));
            check($sformatf("tt%0d_bout", i), 32'(bout_v[0]), 32'(tt[i][0]));
        end

        step(16'h0005, 16'h0003, 1'b1, 1'b1);
        check("w8_5m3_diff", 32'(diff_v[2]), 32'h01);
        check("w8_5m3_bout", 32'(bout_v[2]), 32'd0);
        step(16'h0003, 16'h0005, 1'b0, 1'b1);
        check("w8_3m5_diff", 32'(diff_v[2]), 32'hfe);
        check("w8_3m5_bout", 32'(bout_v[2]), 32'd1);

        step(16'h0001, 16'h0000, 1'b0, 1'b1);
        step(16'h0000, 16'h0001, 1'b0, 1'b0);
        check("hold_diff", 32'(diff_v[2]), 32'h01);
        check("hold_bout", 32'(bout_v[2]), 32'd0);
        check("hold_valid", 32'(ov_v[2]), 32'd0);

        step(16'h0000, 16'h0000, 1'b1, 1'b1);
        check("c0_diff", 32'(diff_v[2]), 32'hff);
        check("c0_bout", 32'(bout_v[2]), 32'd1);
        step(16'h00ff, 16'h00ff, 1'b1, 1'b1);
        check("cff_diff", 32'(diff_v[2]), 32'hff);
        check("cff_bout", 32'(bout_v[2]), 32'd1);
        step(16'h00ff, 16'h0000, 1'b0, 1'b1);
        check("cf0_diff", 32'(diff_v[2]), 32'hff);
        check("cf0_bout", 32'(bout_v[2]), 32'd0);
        step(16'hffff, 16'hffff, 1'b1, 1'b1);
        check("w16_cff_diff", 32'(diff_v[3]), 32'hffff);
        check("w16_cff_bout", 32'(bout_v[3]), 32'd1);

        for (int i = 0; i < 10000; i++) begin
            step(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        end

        @(negedge clk);
        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
